// File: rtl/riot_timer_bank.sv
// Bank of NUM_CH 8-bit interval timers (6530 style) with selectable prescale,
// per-channel IRQ enable and an optional auto-reload mode.
module riot_timer_bank #(
    parameter int NUM_CH    = 2,
    parameter int DIV1_LOG2 = 3,
    parameter int DIV2_LOG2 = 6,
    parameter int DIV3_LOG2 = 10
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       we_n,
    input  logic [4:0] A,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       OE,
    output logic       irq,
    output logic       irq_oe
);
    localparam int PW = DIV3_LOG2;
    localparam logic [PW-1:0] LAST1 = PW'((1 << DIV1_LOG2) - 1);
    localparam logic [PW-1:0] LAST2 = PW'((1 << DIV2_LOG2) - 1);
    localparam logic [PW-1:0] LAST3 = PW'((1 << DIV3_LOG2) - 1);

    logic [7:0]        cnt    [NUM_CH];
    logic [7:0]        reload [NUM_CH];
    logic [1:0]        sel    [NUM_CH];
    logic [PW-1:0]     pre    [NUM_CH];
    logic [NUM_CH-1:0] flag, irq_en, mode, fast;
    logic [NUM_CH-1:0] hit, tick, underflow;
    logic              in_range, wr;
    logic [7:0]        rd_data;

    function automatic logic [PW-1:0] last_of(input logic [1:0] s);
        case (s)
            2'd1:    return LAST1;
            2'd2:    return LAST2;
            default: return LAST3;
        endcase
    endfunction

    assign in_range = int'(A[4:3]) < NUM_CH;
    assign wr       = cs & ~we_n & in_range;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        hit       = '0;
        tick      = '0;
        underflow = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit[c]       = in_range && (A[4:3] == 2'(c));
            tick[c]      = (sel[c] == 2'd0) || fast[c] || (pre[c] == last_of(sel[c]));
            underflow[c] = tick[c] && (cnt[c] == 8'h00);
        end
    end

    // Later non-blocking assignments override earlier ones, giving the
    // write > underflow-set > read-clear priority.
    always_ff @(posedge phi2) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (!rst_n) begin
                // NOTE: the per-channel register arrays are small flops, not RAM, so all of them are reset.
                cnt[c]    <= 8'hFF;
                reload[c] <= 8'hFF;
                sel[c]    <= 2'd3;
                pre[c]    <= '0;
                flag[c]   <= 1'b0;
                irq_en[c] <= 1'b0;
                mode[c]   <= 1'b0;
                fast[c]   <= 1'b0;
            end else begin
                pre[c] <= tick[c] ? '0 : pre[c] + 1'b1;
                if (cs && we_n && hit[c] && !A[2] && !underflow[c])
                    flag[c] <= 1'b0;
                if (tick[c]) begin
                    if (!underflow[c]) begin
                        cnt[c] <= cnt[c] - 8'd1;
                    end else begin
                        flag[c] <= 1'b1;
                        if (mode[c]) begin
                            cnt[c] <= reload[c];
                        end else begin
                            cnt[c]  <= 8'hFF;
                            fast[c] <= 1'b1;
                        end
                    end
                end
                if (wr && hit[c] && !A[2]) begin
                    cnt[c]    <= DI;
                    reload[c] <= DI;
                    sel[c]    <= A[1:0];
                    pre[c]    <= '0;
                    flag[c]   <= 1'b0;
                    fast[c]   <= 1'b0;
                end
                if (wr && hit[c] && A[2] && (A[1:0] == 2'd0)) begin
                    irq_en[c] <= DI[0];
                    mode[c]   <= DI[1];
                end
            end
        end
    end

    // Out-of-range channels match no hit bit and therefore read as zero.
    always_comb begin
        rd_data = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hit[c]) begin
                if (!A[2])
                    rd_data = cnt[c];
                else if (A[1:0] == 2'd0)
                    rd_data = {6'b0, mode[c], irq_en[c]};
                else if (A[1:0] == 2'd1)
                    rd_data = 8'(flag);
            end
        end
    end

    always_ff @(posedge phi2) begin
        if (!rst_n) begin
            DO <= 8'h00;
            OE <= 1'b0;
        end else begin
            OE <= cs & we_n;
            if (cs && we_n)
                DO <= rd_data;
        end
    end

    assign irq    = ~|(flag & irq_en);
    assign irq_oe = |irq_en;

endmodule

// File: tb/tb_riot_timer_bank.sv
// Self-checking bench for riot_timer_bank: fixed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_riot_timer_bank;
    localparam int NUM_CH = 2;

    logic       phi2  = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs    = 1'b0;
    logic       we_n  = 1'b1;
    logic [4:0] A     = 5'h00;
    logic [7:0] DI    = 8'h00;
    logic [7:0] DO;
    logic       OE, irq, irq_oe;

    riot_timer_bank #(
        .NUM_CH(NUM_CH), .DIV1_LOG2(3), .DIV2_LOG2(6), .DIV3_LOG2(10)
    ) dut (
        .phi2(phi2), .rst_n(rst_n), .cs(cs), .we_n(we_n), .A(A), .DI(DI),
        .DO(DO), .OE(OE), .irq(irq), .irq_oe(irq_oe)
    );

    always #5 phi2 = ~phi2;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: each channel counts cycles since its last tick and
    // ticks once a full period has elapsed.
    int         m_cnt[4], m_rel[4], m_sel[4], m_since[4];
    bit         m_flag[4], m_en[4], m_mode[4], m_fast[4];
    logic [7:0] m_do;
    bit         m_oe;

    function automatic int period(int c);
        if (m_sel[c] == 0 || m_fast[c]) return 1;
        case (m_sel[c])
            1:       return 8;
            2:       return 64;
            default: return 1024;
        endcase
    endfunction

    function automatic bit m_irq();
        for (int c = 0; c < NUM_CH; c++)
            if (m_flag[c] && m_en[c]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_irq_oe();
        for (int c = 0; c < NUM_CH; c++)
            if (m_en[c]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 255; m_rel[c] = 255; m_sel[c] = 3; m_since[c] = 0;
            m_flag[c] = 0; m_en[c] = 0; m_mode[c] = 0; m_fast[c] = 0;
        end
        m_do = 8'h00;
        m_oe = 1'b0;
    endtask

    task automatic model_edge(input bit c_s, input bit w, input logic [4:0] a, input logic [7:0] d);
        int         ch;
        bit         hit, tk, under;
        logic [7:0] status;
        ch     = int'(a[4:3]);
        hit    = c_s && (ch < NUM_CH);
        status = 8'h00;
        for (int c = 0; c < NUM_CH; c++) status[c] = m_flag[c];
        m_oe = c_s && w;
        if (c_s && w) begin
            if (!hit)              m_do = 8'h00;
            else if (!a[2])        m_do = 8'(m_cnt[ch]);
            else if (a[1:0] == 0)  m_do = {6'b0, m_mode[ch], m_en[ch]};
            else if (a[1:0] == 1)  m_do = status;
            else                   m_do = 8'h00;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            tk    = (m_since[c] + 1 >= period(c));
            under = tk && (m_cnt[c] == 0);
            m_since[c] = tk ? 0 : m_since[c] + 1;
            if (tk) begin
                if (!under) m_cnt[c] = m_cnt[c] - 1;
                else begin
                    m_flag[c] = 1;
                    if (m_mode[c]) m_cnt[c] = m_rel[c];
                    else begin m_cnt[c] = 255; m_fast[c] = 1; end
                end
            end
            if (hit && ch == c) begin
                if (w && !a[2] && !under) m_flag[c] = 0;
                if (!w && !a[2]) begin
                    m_cnt[c] = int'(d); m_rel[c] = int'(d); m_sel[c] = int'(a[1:0]);
                    m_since[c] = 0; m_flag[c] = 0; m_fast[c] = 0;
                end
                if (!w && a[2] && a[1:0] == 2'd0) begin
                    m_en[c] = d[0]; m_mode[c] = d[1];
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got DO/OE/irq/irq_oe=%h/%b/%b/%b expected %h/%b/%b/%b",
                     name, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic expect_out(input string name, input logic [7:0] d, input bit oe, input bit iq, input bit iq_oe);
        check(name, {DO, OE, irq, irq_oe}, {d, oe, iq, iq_oe});
    endtask

    task automatic apply(input bit c_s, input bit w, input logic [4:0] a, input logic [7:0] d);
        cs = c_s; we_n = w; A = a; DI = d;
        @(posedge phi2);
        #1;
        model_edge(c_s, w, a, d);
        cs = 1'b0; we_n = 1'b1;
    endtask

    task automatic reset_edge(input bit c_s, input bit w, input logic [4:0] a, input logic [7:0] d);
        cs = c_s; we_n = w; A = a; DI = d; rst_n = 1'b0;
        @(posedge phi2);
        #1;
        rst_n = 1'b1; cs = 1'b0; we_n = 1'b1;
        model_reset();
    endtask

    task automatic do_reset();
        reset_edge(1'b0, 1'b1, 5'h00, 8'h00);
        reset_edge(1'b0, 1'b1, 5'h00, 8'h00);
    endtask

    typedef struct {
        bit         cs;
        bit         we_n;
        logic [4:0] a;
        logic [7:0] di;
        logic [7:0] exp_do;
        bit         exp_oe;
        bit         exp_irq;
        bit         exp_irq_oe;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [7:0] exp_a [4];
        logic [7:0] exp_b [7];
        bit         irq_b [7];

        tbl[0]  = '{0, 1, 5'h00, 8'h00, 8'h00, 0, 1, 0};  // idle after reset
        tbl[1]  = '{1, 1, 5'h05, 8'h00, 8'h00, 1, 1, 0};  // status read
        tbl[2]  = '{1, 0, 5'h00, 8'h05, 8'h00, 0, 1, 0};  // ch0 := 5, sel 0
        tbl[3]  = '{1, 1, 5'h00, 8'h00, 8'h05, 1, 1, 0};
        tbl[4]  = '{1, 1, 5'h00, 8'h00, 8'h04, 1, 1, 0};
        tbl[5]  = '{1, 0, 5'h0C, 8'h01, 8'h04, 0, 1, 1};  // ch1 irq_en
        tbl[6]  = '{1, 1, 5'h0C, 8'h00, 8'h01, 1, 1, 1};
        tbl[7]  = '{1, 0, 5'h18, 8'h77, 8'h01, 0, 1, 1};  // out-of-range write
        tbl[8]  = '{1, 1, 5'h18, 8'h00, 8'h00, 1, 1, 1};  // out-of-range read, ch0 underflows
        tbl[9]  = '{1, 1, 5'h05, 8'h00, 8'h01, 1, 1, 1};
        tbl[10] = '{1, 1, 5'h00, 8'h00, 8'hFE, 1, 1, 1};  // fast mode, read clears flag
        tbl[11] = '{1, 1, 5'h05, 8'h00, 8'h00, 1, 1, 1};
        tbl[12] = '{1, 0, 5'h08, 8'h00, 8'h00, 0, 1, 1};  // ch1 := 0, sel 0
        tbl[13] = '{0, 1, 5'h08, 8'h00, 8'h00, 0, 0, 1};  // ch1 underflow -> irq low
        tbl[14] = '{1, 1, 5'h08, 8'h00, 8'hFF, 1, 1, 1};  // ch1 read releases irq
        tbl[15] = '{1, 1, 5'h04, 8'h00, 8'h00, 1, 1, 1};

        model_reset();
        do_reset();
        expect_out("reset", 8'h00, 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].cs, tbl[i].we_n, tbl[i].a, tbl[i].di);
            expect_out($sformatf("vec%0d", i), tbl[i].exp_do, tbl[i].exp_oe, tbl[i].exp_irq, tbl[i].exp_irq_oe);
        end

        // Divide-by-8 countdown, underflow on the 32nd edge, then fast mode.
        do_reset();
        apply(1, 0, 5'h04, 8'h01);
        apply(1, 0, 5'h01, 8'h03);
        exp_a = '{8'h03, 8'h02, 8'h01, 8'h00};
        for (int k = 1; k <= 35; k++) begin
            if (k % 8 == 1 && k <= 25) begin
                apply(1, 1, 5'h00, 8'h00);
                expect_out($sformatf("div8_k%0d", k), exp_a[k / 8], 1, 1, 1);
            end else if (k == 31) begin
                apply(0, 1, 5'h00, 8'h00);
                expect_out("div8_pre_underflow", 8'h00, 0, 1, 1);
            end else if (k == 32) begin
                apply(1, 1, 5'h05, 8'h00);
                expect_out("div8_underflow", 8'h00, 1, 0, 1);
            end else if (k >= 33) begin
                apply(1, 1, 5'h00, 8'h00);
                expect_out($sformatf("div8_fast_k%0d", k), 8'(8'hFF - (k - 33)), 1, 1, 1);
            end else begin
                apply(0, 1, 5'h00, 8'h00);
            end
        end

        // Auto-reload with reload value 2 and sel 0.
        do_reset();
        apply(1, 0, 5'h04, 8'h03);
        apply(1, 0, 5'h00, 8'h02);
        exp_b = '{8'h02, 8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02};
        irq_b = '{1, 1, 0, 1, 1, 0, 1};
        for (int k = 0; k < 7; k++) begin
            apply(1, 1, 5'h00, 8'h00);
            expect_out($sformatf("reload_e%0d", k + 1), exp_b[k], 1, irq_b[k], 1);
        end

        // Collisions: write on the underflow edge, then read on the underflow edge.
        do_reset();
        apply(1, 0, 5'h00, 8'h01);
        apply(0, 1, 5'h00, 8'h00);
        apply(1, 0, 5'h00, 8'h10);
        apply(1, 1, 5'h05, 8'h00);
        expect_out("coll_write_flag", 8'h00, 1, 1, 0);
        apply(1, 1, 5'h00, 8'h00);
        expect_out("coll_write_cnt", 8'h0F, 1, 1, 0);
        apply(1, 0, 5'h00, 8'h00);
        apply(1, 1, 5'h00, 8'h00);
        expect_out("coll_read_do", 8'h00, 1, 1, 0);
        apply(1, 1, 5'h05, 8'h00);
        expect_out("coll_read_flag", 8'h01, 1, 1, 0);

        // Channel isolation and out-of-range control writes.
        do_reset();
        apply(1, 0, 5'h0A, 8'h40);
        apply(1, 0, 5'h04, 8'h02);
        apply(1, 0, 5'h00, 8'h03);
        repeat (6) apply(1, 1, 5'h00, 8'h00);
        apply(1, 0, 5'h18, 8'h55);
        apply(1, 0, 5'h1C, 8'h03);
        apply(1, 1, 5'h08, 8'h00);
        expect_out("iso_ch1_cnt", 8'h40, 1, 1, 0);
        apply(1, 1, 5'h0C, 8'h00);
        expect_out("iso_ch1_ctl", 8'h00, 1, 1, 0);
        apply(1, 1, 5'h04, 8'h00);
        expect_out("iso_ch0_ctl", 8'h02, 1, 1, 0);
        apply(1, 1, 5'h1C, 8'h00);
        expect_out("iso_oor_ctl", 8'h00, 1, 1, 0);

        // Randomized traffic against the model, with one reset mid-run.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int         r;
            logic [4:0] a;
            logic [7:0] d;
            bit         c_s, w;
            r   = int'($urandom_range(99));
            a   = 5'($urandom);
            d   = 8'($urandom);
            c_s = 1'b1;
            w   = 1'b1;
            if (r < 50) begin
                c_s = 1'b0; w = 1'($urandom);
            end else if (r < 68) begin
                a[2] = 1'b0;
            end else if (r < 80) begin
                w = 1'b0; a[2] = 1'b0; a[1:0] = 2'($urandom_range(2));
                if ($urandom_range(1) == 1) d = 8'($urandom_range(6));
            end else if (r < 90) begin
                w = 1'b0; a[2] = 1'b1;
                if ($urandom_range(1) == 1) a[1:0] = 2'b00;
            end else begin
                a[2] = 1'b1;
            end
            if (i == 1500) reset_edge(c_s, w, a, d);
            else           apply(c_s, w, a, d);
            check($sformatf("rand%0d", i), {DO, OE, irq, irq_oe}, {m_do, m_oe, m_irq(), m_irq_oe()});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
